// File: rtl/rom_streamer_pkg.sv
// rtl/rom_streamer_pkg.sv - shared state encoding for the ROM read streamer
package rom_streamer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/rom_streamer_if.sv
// rtl/rom_streamer_if.sv - output word stream between the streamer and its consumer
interface rom_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fifo2.sv
// rtl/fifo2.sv - two-entry synchronous FIFO with occupancy count
module fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [1:0]       cnt
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt_q;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign cnt     = cnt_q;
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - walks consecutive ROM addresses and streams the words out
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    rom_streamer_if.master        out_if
);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   popped;
    logic                  inflight;
    logic                  inflight_last;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occ;
    logic [1:0]            fifo_cnt;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH:0]   fifo_rd;

    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign rom_addr = addr_q;

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = fifo_rd[DATA_WIDTH-1:0];
    assign out_if.out_last  = fifo_rd[DATA_WIDTH] && !fifo_empty;

    assign pop = out_if.out_valid && out_if.out_ready;

    // Words already buffered plus the one still coming out of the ROM; a pop
    // this cycle frees a slot, so a read may be issued into it immediately.
    assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight};
    assign issue = (state == ST_RUN) && (issued < count_q)
                 && (occ < (3'd2 + {2'b00, pop}));

    fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight && !fifo_full),
        .wr_data ({inflight_last, rom_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .cnt     (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            count_q       <= '0;
            issued        <= '0;
            popped        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (issued == count_q - CNT_ONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        count_q <= count;
                        issued  <= '0;
                        popped  <= '0;
                        state   <= (count == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr_q <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        issued <= issued + CNT_ONE;
                    end
                    if (pop) begin
                        popped <= popped + CNT_ONE;
                        if (popped == count_q - CNT_ONE) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - directed self-checking bench for rom_streamer
module tb_rom_streamer;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    rom_streamer_if #(.DATA_WIDTH(DW)) s ();

    rom_streamer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_if    (s.master)
    );

    always #5 clk = ~clk;

    // ROM contents: word = address + 0x10, one-cycle registered read
    always @(posedge clk) rom_data <= 8'h10 + {2'b00, rom_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [AW-1:0] b, input logic [AW:0] c);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s.out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (s.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", s.out_valid); end
        n_cmp++; if (s.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", s.out_last); end
        n_cmp++; if (s.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", s.out_data); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        s.out_ready = 1'b1;
        kick(6'd0, 7'd4);
        n_cmp++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL basic_first_addr got %0d want 0", rom_addr); end
        for (int c = 1; c <= 9; c++) begin
            logic ev, el, ed_done, eb;
            logic [7:0] ed;
            ev = (c >= 3) && (c <= 6);
            el = (c == 6);
            ed_done = (c == 7);
            eb = (c >= 1) && (c <= 6);
            ed = 8'h10 + 8'(c - 3);
            n_cmp++; if (s.out_valid !== ev) begin n_fail++; $display("FAIL basic_valid c%0d got %b want %b", c, s.out_valid, ev); end
            n_cmp++; if (done !== ed_done) begin n_fail++; $display("FAIL basic_done c%0d got %b want %b", c, done, ed_done); end
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL basic_busy c%0d got %b want %b", c, busy, eb); end
            if (ev) begin
                n_cmp++; if (s.out_data !== ed) begin n_fail++; $display("FAIL basic_data c%0d got %h want %h", c, s.out_data, ed); end
                n_cmp++; if (s.out_last !== el) begin n_fail++; $display("FAIL basic_last c%0d got %b want %b", c, s.out_last, el); end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h4E; exp_d[1] = 8'h4F; exp_d[2] = 8'h10; exp_d[3] = 8'h11;
        s.out_ready = 1'b1;
        kick(6'd62, 7'd4);
        for (int c = 1; c <= 8; c++) begin
            if (c >= 3 && c <= 6) begin
                n_cmp++; if (s.out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid c%0d got %b want 1", c, s.out_valid); end
                n_cmp++; if (s.out_data !== exp_d[c-3]) begin n_fail++; $display("FAIL wrap_data c%0d got %h want %h", c, s.out_data, exp_d[c-3]); end
            end
            n_cmp++; if (done !== (c == 7)) begin n_fail++; $display("FAIL wrap_done c%0d got %b want %b", c, done, (c == 7)); end
            step();
        end
    endtask

    task automatic test_zero_count();
        s.out_ready = 1'b1;
        kick(6'd7, 7'd0);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (done !== (c == 1)) begin n_fail++; $display("FAIL zero_done c%0d got %b want %b", c, done, (c == 1)); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy c%0d got %b want 0", c, busy); end
            n_cmp++; if (s.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid c%0d got %b want 0", c, s.out_valid); end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic [7:0]  prev_data;
        logic        prev_stall;
        int          n_beats;
        int          n_done;
        pat = 16'b1001_0110_1100_1001;
        prev_stall = 1'b0;
        prev_data = '0;
        n_beats = 0;
        n_done = 0;
        s.out_ready = 1'b0;
        kick(6'd10, 7'd8);
        for (int c = 1; c <= 60; c++) begin
            s.out_ready = pat[c % 16];
            if (prev_stall) begin
                n_cmp++; if (s.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got %b want 1", c, s.out_valid); end
                n_cmp++; if (s.out_data !== prev_data) begin n_fail++; $display("FAIL bp_hold_data c%0d got %h want %h", c, s.out_data, prev_data); end
            end
            if (s.out_valid && s.out_ready) begin
                n_cmp++; if (s.out_data !== 8'(8'h1A + n_beats)) begin n_fail++; $display("FAIL bp_data beat%0d got %h want %h", n_beats, s.out_data, 8'(8'h1A + n_beats)); end
                n_cmp++; if (s.out_last !== (n_beats == 7)) begin n_fail++; $display("FAIL bp_last beat%0d got %b want %b", n_beats, s.out_last, (n_beats == 7)); end
                n_beats++;
            end
            if (done) n_done++;
            prev_stall = s.out_valid && !s.out_ready;
            prev_data = s.out_data;
            step();
        end
        n_cmp++; if (n_beats != 8) begin n_fail++; $display("FAIL bp_beat_count got %0d want 8", n_beats); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_count got %0d want 1", n_done); end
        s.out_ready = 1'b1;
    endtask

    task automatic test_full_range();
        s.out_ready = 1'b1;
        kick(6'd5, 7'd64);
        for (int c = 1; c <= 72; c++) begin
            logic [AW-1:0] a;
            logic [7:0]    ed;
            logic          ev;
            // stray commands mid-run must have no effect
            start = (c == 10) || (c == 30);
            base_addr = 6'd0;
            count = 7'd1;
            a = 6'(5 + c - 3);
            ed = 8'h10 + {2'b00, a};
            ev = (c >= 3) && (c <= 66);
            n_cmp++; if (s.out_valid !== ev) begin n_fail++; $display("FAIL full_valid c%0d got %b want %b", c, s.out_valid, ev); end
            if (ev) begin
                n_cmp++; if (s.out_data !== ed) begin n_fail++; $display("FAIL full_data c%0d got %h want %h", c, s.out_data, ed); end
                n_cmp++; if (s.out_last !== (c == 66)) begin n_fail++; $display("FAIL full_last c%0d got %b want %b", c, s.out_last, (c == 66)); end
            end
            n_cmp++; if (done !== (c == 67)) begin n_fail++; $display("FAIL full_done c%0d got %b want %b", c, done, (c == 67)); end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        s.out_ready = 1'b1;
        kick(6'd20, 7'd10);
        step();
        step();
        step();
        n_cmp++; if (s.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", s.out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (s.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", s.out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_cmp++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL mid_rom_addr got %0d want 0", rom_addr); end
        n_cmp++; if (s.out_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %h want 00", s.out_data); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", done); end
        step();
        rst_n = 1'b1;
        step();
        kick(6'd40, 7'd3);
        for (int c = 1; c <= 7; c++) begin
            logic ev;
            ev = (c >= 3) && (c <= 5);
            n_cmp++; if (s.out_valid !== ev) begin n_fail++; $display("FAIL after_valid c%0d got %b want %b", c, s.out_valid, ev); end
            if (ev) begin
                n_cmp++; if (s.out_data !== 8'(8'h38 + c - 3)) begin n_fail++; $display("FAIL after_data c%0d got %h want %h", c, s.out_data, 8'(8'h38 + c - 3)); end
            end
            n_cmp++; if (done !== (c == 6)) begin n_fail++; $display("FAIL after_done c%0d got %b want %b", c, done, (c == 6)); end
            step();
        end
    endtask

    initial begin
        s.out_ready = 1'b1;
        #1;
        test_reset();
        test_basic();
        step();
        test_wrap();
        step();
        test_zero_count();
        test_backpressure();
        step();
        test_full_range();
        step();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
